// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle pulses into fixed high windows with a
// mandatory low gap; extra pulses queue in a saturating pending counter.
module pulse_stretch #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pulse_in,
    output logic                  level_out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    localparam int MAXC =
        (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [PEND_WIDTH-1:0]   pend_nxt;
    logic                    ovf_nxt;
    logic                    last;

    assign last = (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pending;
        ovf_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
                if (pulse_in) begin
                    if (pending == PEND_MAX) ovf_nxt = 1'b1;
                    else pend_nxt = pending + 1'b1;
                end
            end
            GAP: begin
                if (last) begin
                    // A pulse landing now is consumed by the restart itself.
                    if (pending != '0 || pulse_in) begin
                        state_nxt = HIGH;
                        cnt_nxt   = HOLD_LOAD;
                        if (!pulse_in) pend_nxt = pending - 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (pulse_in) begin
                        if (pending == PEND_MAX) ovf_nxt = 1'b1;
                        else pend_nxt = pending + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending   <= pend_nxt;
            overflow  <= ovf_nxt;
            level_out <= (state_nxt == HIGH);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed and random checks of pulse_stretch against a
// window-scheduling reference model (HOLD=4/GAP=2 and HOLD=1/GAP=1).
module tb_pulse_stretch;

    logic       clock = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic       lvl0, busy0, ovf0;
    logic [1:0] pend0;
    logic       lvl1, busy1, ovf1;
    logic [1:0] pend1;

    always #5 clock = ~clock;

    pulse_stretch #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .PEND_WIDTH (2)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level_out(lvl0),
        .busy     (busy0),
        .pending  (pend0),
        .overflow (ovf0)
    );

    pulse_stretch #(
        .HOLD_CYCLES(1),
        .GAP_CYCLES (1),
        .PEND_WIDTH (2)
    ) u_dut1 (
        .clock    (clock),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level_out(lvl1),
        .busy     (busy1),
        .pending  (pend1),
        .overflow (ovf1)
    );

    localparam int QMAX = 3;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    // Model: each window starts at output cycle s, is high for H cycles and
    // low for G; the pulse sampled in cycle s+H+G-1 is the final-gap pulse.
    int m_h[2] = '{4, 1};
    int m_g[2] = '{2, 1};
    bit m_act[2];
    int m_s[2];
    int m_q[2];
    bit m_ovf[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_s[i]   = 0;
            m_q[i]   = 0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(int i, bit p, int c);
        m_ovf[i] = 1'b0;
        if (!m_act[i]) begin
            if (p) begin
                m_act[i] = 1'b1;
                m_s[i]   = c + 1;
            end
        end else if (c == m_s[i] + m_h[i] + m_g[i] - 1) begin
            if (m_q[i] > 0 || p) begin
                m_q[i] = m_q[i] + int'(p) - 1;
                m_s[i] = c + 1;
            end else begin
                m_act[i] = 1'b0;
            end
        end else if (p) begin
            if (m_q[i] == QMAX) m_ovf[i] = 1'b1;
            else m_q[i] = m_q[i] + 1;
        end
    endfunction

    function automatic logic [4:0] expv(int i);
        logic lv;
        lv = m_act[i] && (cyc + 1 < m_s[i] + m_h[i]);
        return {lv, m_act[i], 2'(m_q[i]), m_ovf[i]};
    endfunction

    function automatic logic [4:0] obs(int i);
        if (i == 0) return {lvl0, busy0, pend0, ovf0};
        return {lvl1, busy1, pend1, ovf1};
    endfunction

    task automatic tick(input bit p);
        pulse_in = p;
        @(posedge clock);
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) model_edge(i, p, cyc);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pulse_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pulse_in = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs(i) !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_hold dut%0d got=%b want=%b",
                         i, obs(i), 5'b0);
            end
        end
        do_reset();
        vectors++;
        if (obs(0) !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=%b", obs(0), 5'b0);
        end
    endtask

    task automatic test_single();
        logic [4:0] want;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick(e == 10);
            want = {(e >= 10 && e <= 13), (e >= 10 && e <= 15), 3'b000};
            vectors++;
            if (obs(0) !== want) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%b want=%b",
                         e + 1, obs(0), want);
            end
        end
    endtask

    task automatic test_queue();
        logic lv;
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            tick(e == 10 || e == 12 || e == 13);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL queue cyc=%0d got=%b want=%b",
                         e + 1, obs(0), expv(0));
            end
            lv = (e >= 10 && e <= 13) || (e >= 16 && e <= 19) ||
                 (e >= 22 && e <= 25);
            vectors++;
            if (lvl0 !== lv) begin
                miscompares++;
                $display("FAIL queue_window cyc=%0d got=%b want=%b",
                         e + 1, lvl0, lv);
            end
        end
    endtask

    task automatic test_overflow();
        int   rises = 0;
        int   lowrun = 0;
        int   mingap = 1000;
        logic prev = 1'b0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick(e >= 10 && e <= 15);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL overflow cyc=%0d got=%b want=%b",
                         e + 1, obs(0), expv(0));
            end
            if (e == 14 || e == 15) begin
                vectors++;
                if ({ovf0, pend0} !== 3'b111) begin
                    miscompares++;
                    $display("FAIL overflow_strobe cyc=%0d got=%b want=%b",
                             e + 1, {ovf0, pend0}, 3'b111);
                end
            end
            if (lvl0 && !prev) begin
                if (rises > 0 && lowrun < mingap) mingap = lowrun;
                rises++;
            end
            lowrun = lvl0 ? 0 : lowrun + 1;
            prev   = lvl0;
        end
        vectors++;
        if (rises != 4 || mingap < 2) begin
            miscompares++;
            $display("FAIL overflow_windows got=%0d/%0d want=4/>=2",
                     rises, mingap);
        end
    endtask

    task automatic test_final_gap();
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            tick(e == 10 || e == 16);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL final_gap cyc=%0d got=%b want=%b",
                         e + 1, obs(0), expv(0));
            end
            if (e >= 10 && e <= 21) begin
                vectors++;
                if (busy0 !== 1'b1 || pend0 !== 2'd0) begin
                    miscompares++;
                    $display("FAIL final_gap_busy cyc=%0d got=%b%b want=100",
                             e + 1, busy0, pend0);
                end
            end
            if (e >= 16 && e <= 19) begin
                vectors++;
                if (lvl0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL final_gap_level cyc=%0d got=%b want=1",
                             e + 1, lvl0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick(e >= 10 && e <= 12);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL async_pre cyc=%0d got=%b want=%b",
                         e + 1, obs(0), expv(0));
            end
        end
        vectors++;
        if ({lvl0, pend0} !== 3'b110) begin
            miscompares++;
            $display("FAIL async_setup got=%b want=110", {lvl0, pend0});
        end
        pulse_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs(0) !== 5'b0) begin
            miscompares++;
            $display("FAIL async_abort got=%b want=%b", obs(0), 5'b0);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
        for (int e = 1; e <= 15; e++) begin
            tick(1'b0);
            vectors++;
            if (obs(0) !== 5'b0) begin
                miscompares++;
                $display("FAIL async_after cyc=%0d got=%b want=%b",
                         e + 1, obs(0), 5'b0);
            end
        end
    endtask

    task automatic test_hold1();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick(e == 5 || e == 6);
            vectors++;
            if (obs(1) !== expv(1)) begin
                miscompares++;
                $display("FAIL hold1 cyc=%0d got=%b want=%b",
                         e + 1, obs(1), expv(1));
            end
            vectors++;
            if (lvl1 !== (e == 5 || e == 7)) begin
                miscompares++;
                $display("FAIL hold1_level cyc=%0d got=%b want=%b",
                         e + 1, lvl1, (e == 5 || e == 7));
            end
        end
    endtask

    task automatic test_random();
        bit p;
        do_reset();
        for (int e = 1; e <= 600; e++) begin
            if (e % 150 < 20) p = ($urandom_range(0, 3) != 0);
            else p = ($urandom_range(0, 5) == 0);
            tick(p);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc=%0d got=%b want=%b",
                             i, e + 1, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        pulse_in = 1'b0;
        reset    = 1'b1;
        cyc      = 0;
        model_reset();
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_final_gap();
        test_async_reset();
        test_hold1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
